lfsr_checker: RTL

- Receive-side companion to the 16-bit LFSR pattern generator.
- Accepts the 16-bit word stream produced by the generator, self-synchronises to it, predicts each next word, and flags and counts mismatches.
- Used on-chip or in a loopback path to check that LFSR-driven training data arrives intact. Reports lock status and a saturating error count.

---
 rtl/lfsr_pkg.sv | 26 ++
 rtl/lfsr_checker_step.sv | 11 +
 rtl/lfsr_checker.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Definitions shared by the 16-bit LFSR pattern generator and its checker:
// word width, seed, feedback taps and the checker state encoding.
package lfsr_pkg;

    localparam int          LFSR_W    = 16;
    localparam logic [15:0] LFSR_SEED = 16'h0001;

    // Feedback taps: next[0] = q[1] ^ q[2] ^ q[4] ^ q[15]
    localparam logic [15:0] LFSR_TAPS = 16'h8016;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } chk_state_e;

    // Number of set bits in a 16-bit word
    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/lfsr_checker_step.sv
// Combinational single step of the 16-bit LFSR: shift left, feedback into bit 0.
module lfsr_step
    import lfsr_pkg::*;
(
    input  logic [LFSR_W-1:0] q_i,
    output logic [LFSR_W-1:0] next_o
);

    assign next_o = {q_i[LFSR_W-2:0], ^(q_i & LFSR_TAPS)};

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side checker for the 16-bit LFSR pattern stream.
// Self-synchronises from the incoming words, then flywheels its own
// prediction while locked, flagging and counting mismatching words.
// Optional build macro LFSR_CHK_BIT_ERR_EN enables the mismatched-bit counter;
// without it bit_err_cnt_o is tied to zero.
//
//  state  | meaning
//  SEARCH | seeding prediction from data_i, counting consecutive matches
//  LOCKED | prediction free-runs; mismatches are flagged and counted
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 4,
    parameter int ERR_W      = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [15:0]       data_i,
    input  logic              clr_i,
    output logic              locked_o,
    output logic              err_o,
    output logic [ERR_W-1:0]  err_cnt_o,
    output logic [ERR_W-1:0]  bit_err_cnt_o
);

    localparam logic [3:0] LOCK_C   = 4'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_C = 4'(UNLOCK_CNT);

    chk_state_e        state_q, state_d;
    logic [15:0]       pred_q, pred_d;
    logic              pred_vld_q, pred_vld_d;
    logic [3:0]        run_q, run_d;
    logic              locked_q, locked_d;
    logic              err_q, err_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

    logic [15:0]       f_pred, f_data;
    logic [3:0]        run_inc;
    logic              locked_miss;

    // Same step function for the flywheel path and the resync path
    lfsr_step u_step_pred (.q_i(pred_q), .next_o(f_pred));
    lfsr_step u_step_data (.q_i(data_i), .next_o(f_data));

    // Next-state logic for lock tracking, prediction and word error count
    always_comb begin
        state_d     = state_q;
        pred_d      = pred_q;
        pred_vld_d  = pred_vld_q;
        run_d       = run_q;
        locked_d    = locked_q;
        err_cnt_d   = err_cnt_q;
        run_inc     = run_q + 4'd1;
        locked_miss = en_i && (state_q == LOCKED) && (data_i != pred_q);
        err_d       = locked_miss;

        if (en_i) begin
            case (state_q)
                SEARCH: begin
                    if (data_i == 16'h0000) begin
                        // lock-up value never seeds a prediction
                        pred_vld_d = 1'b0;
                        run_d      = 4'd0;
                    end else begin
                        pred_d     = f_data;
                        pred_vld_d = 1'b1;
                        if (pred_vld_q && (data_i == pred_q)) begin
                            if (run_inc == LOCK_C) begin
                                state_d  = LOCKED;
                                locked_d = 1'b1;
                                run_d    = 4'd0;
                            end else begin
                                run_d = run_inc;
                            end
                        end else begin
                            run_d = 4'd0;
                        end
                    end
                end
                LOCKED: begin
                    pred_d = f_pred;
                    if (locked_miss) begin
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + ERR_W'(1);
                        end
                        if (run_inc == UNLOCK_C) begin
                            state_d    = SEARCH;
                            locked_d   = 1'b0;
                            run_d      = 4'd0;
                            pred_d     = f_data;
                            pred_vld_d = (data_i != 16'h0000);
                        end else begin
                            run_d = run_inc;
                        end
                    end else begin
                        run_d = 4'd0;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        if (clr_i) begin
            err_cnt_d = '0;
        end
    end

    // Register all state and outputs; reset wins over every other input
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= SEARCH;
            pred_q     <= '0;
            pred_vld_q <= 1'b0;
            run_q      <= '0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            pred_q     <= pred_d;
            pred_vld_q <= pred_vld_d;
            run_q      <= run_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign locked_o  = locked_q;
    assign err_o     = err_q;
    assign err_cnt_o = err_cnt_q;

`ifdef LFSR_CHK_BIT_ERR_EN
    localparam int SUM_W = ERR_W + 5;

    logic [ERR_W-1:0] bit_err_cnt_q, bit_err_cnt_d;
    logic [SUM_W-1:0] bit_sum;

    // Accumulate mismatched bits of each locked mismatch, saturating
    always_comb begin
        bit_err_cnt_d = bit_err_cnt_q;
        bit_sum       = SUM_W'(bit_err_cnt_q) + SUM_W'(popcount16(data_i ^ pred_q));
        if (locked_miss) begin
            bit_err_cnt_d = (|bit_sum[SUM_W-1:ERR_W]) ? '1 : bit_sum[ERR_W-1:0];
        end
        if (clr_i) begin
            bit_err_cnt_d = '0;
        end
    end

    // Bit error counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bit_err_cnt_q <= '0;
        end else begin
            bit_err_cnt_q <= bit_err_cnt_d;
        end
    end

    assign bit_err_cnt_o = bit_err_cnt_q;
`else
    assign bit_err_cnt_o = '0;
`endif

endmodule
